// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants and state type for the UART program loader.
package uart_loader_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} ld_state_t;
endpackage

// File: rtl/uart_loader_word_packer.sv
// uart_word_packer: assembles four little-endian bytes into a 32-bit word.
module uart_word_packer
    import uart_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [31:0]       word,
    output logic [31:0]       word_next,
    output logic              word_valid
);
    logic [1:0] cnt;
    // word_next lets the loader decode a word in the same cycle its last byte arrives
    assign word_next  = {byte_in, word[31:8]};
    assign word_valid = en && cnt == 2'd3;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= 2'd0;
            word <= 32'd0;
        end else if (en) begin
            cnt  <= cnt + 2'd1;
            word <= word_next;
        end
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: pops a length-prefixed little-endian image from the UART
// receive buffer and writes it word by word into instruction memory from address 0.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] rdata,
    output logic              next,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0]   ONE_W = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    ld_state_t       state, state_n;
    logic            pop_d, word_valid, oversize;
    logic [31:0]     word, word_next;
    logic [ADDR_W:0] words_left;
    // pop_d blocks back-to-back pops so the buffer's flag has a cycle to settle
    assign next       = rx_ready && !pop_d && (state == HDR || state == DATA);
    assign oversize   = {1'b0, word_next} > (33'd1 << ADDR_W);
    assign imem_we    = state == WRITE;
    assign imem_wdata = word;
    assign busy       = state == HDR || state == DATA || state == WRITE;
    assign done       = state == DONE;
    assign err        = state == ERR;
    uart_word_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .en         (next),
        .byte_in    (rdata),
        .word       (word),
        .word_next  (word_next),
        .word_valid (word_valid)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            pop_d <= 1'b0;
        end else begin
            state <= state_n;
            pop_d <= next;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? HDR : IDLE;
            HDR:     if (word_valid) state_n = word_next == 32'd0 ? DONE : oversize ? ERR : DATA;
            DATA:    state_n = word_valid ? WRITE : DATA;
            WRITE:   state_n = words_left == ONE_W ? DONE : DATA;
            DONE:    state_n = start ? HDR : DONE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            words_left <= '0;
            imem_addr  <= '0;
        end else if (state == HDR && word_valid) begin
            words_left <= word_next[ADDR_W:0];
            imem_addr  <= '0;
        end else if (state == WRITE) begin
            words_left <= words_left - ONE_W;
            imem_addr  <= imem_addr + ONE_A;
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for uart_loader with a queue-modelled receive buffer.
module tb_uart_loader;
    localparam int ADDR_W = 4;
    logic              clk = 1'b0, rstn = 1'b0, start = 1'b0, rx_ready = 1'b0;
    logic [7:0]        rdata = 8'h00;
    logic              next, imem_we, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    int                vectors = 0, miscompares = 0, cyc = 0, last_pop = -1, last_we = -1;
    logic [7:0]        rxq[$];
    logic [ADDR_W+31:0] expq[$];
    logic [ADDR_W+31:0] exp_w;
    logic              prev_next = 1'b0;

    uart_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .next       (next),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // monitor: every write strobe is matched against the head of the expected queue
    always @(negedge clk) begin
        if (imem_we) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL write: unexpected write addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                exp_w = expq.pop_front();
                if ({imem_addr, imem_wdata} !== exp_w) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                             imem_addr, imem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
                end
            end
        end
        if (next && prev_next) begin
            miscompares++;
            $display("FAIL next_spacing: got next=1 in consecutive cycles want at most one per two");
        end
        prev_next <= next;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        rx_ready = rxq.size() != 0;
        rdata    = rx_ready ? rxq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) push(w[8*i +: 8]);
    endtask

    task automatic step();
        logic       p;
        logic [7:0] b;
        @(negedge clk);
        p = next;
        @(posedge clk);
        #1;
        cyc++;
        if (p) begin
            last_pop = cyc - 1;
            b = rxq.pop_front();
        end
        refresh();
        if (imem_we) last_we = cyc;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (!done && !err && n < budget) begin
            step();
            n++;
        end
        if (!done && !err) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no done/err within %0d cycles want completion", name, budget);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (rxq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (rxq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0d bytes left want 0 within %0d cycles", name, rxq.size(), budget);
        end
    endtask

    initial begin
        int lw;
        logic [31:0] w;
        repeat (3) step();
        rstn = 1'b1;
        chk("reset_outputs", {next, imem_we, imem_addr, imem_wdata, busy, done, err}, 0);

        // bytes waiting while idle must stay in the buffer
        push_word(32'd2);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        repeat (4) step();
        chk("idle_no_pop", rxq.size(), 12);
        chk("idle_next", next, 0);
        chk("idle_rx_ready", rx_ready, 1);

        expq.push_back({4'd0, 32'h12345678});
        expq.push_back({4'd1, 32'hDEADBEEF});
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_first_pop", next, 1);
        wait_end("load2", 100);
        chk("load2_done", done, 1);
        chk("load2_done_timing", cyc, last_we + 1);
        chk("load2_busy", busy, 0);
        chk("load2_drained", rxq.size(), 0);
        chk("load2_writes", expq.size(), 0);

        // empty image completes straight from the header
        lw = last_we;
        push_word(32'd0);
        pulse_start();
        wait_end("empty", 50);
        chk("empty_done", {done, err}, 2'b10);
        chk("empty_timing", cyc, last_pop + 1);
        chk("empty_no_write", last_we, lw);

        pulse_start();
        chk("rearm_busy", {busy, done}, 2'b10);

        // full-capacity image with stalls between words; address wraps to 0 at the end
        push_word(32'd16);
        for (int i = 0; i < 16; i++) begin
            w = {8'(i), 8'hC3, 8'(i * 3), 8'h5A};
            push_word(w);
            expq.push_back({4'(i), w});
            repeat (12) step();
        end
        wait_end("full", 200);
        chk("full_done", {done, err}, 2'b10);
        chk("full_writes", expq.size(), 0);
        chk("full_addr_wrap", imem_addr, 0);

        // reset in the middle of word 1 discards the partial word
        push_word(32'd1);
        push(8'h11);
        push(8'h22);
        pulse_start();
        wait_drain("midrst_drain", 40);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("midrst_outputs", {next, imem_we, imem_addr, imem_wdata, busy, done, err}, 0);
        push_word(32'd1);
        push_word(32'hCAFEF00D);
        expq.push_back({4'd0, 32'hCAFEF00D});
        pulse_start();
        wait_end("reload", 50);
        chk("reload_done", done, 1);
        chk("reload_writes", expq.size(), 0);

        // N=17 exceeds 16 words: sticky error, trailing bytes left unpopped
        push_word(32'd17);
        push(8'hAA);
        push(8'hBB);
        pulse_start();
        wait_end("oversize", 50);
        chk("err_flag", {err, done}, 2'b10);
        chk("err_timing", cyc, last_pop + 1);
        repeat (8) step();
        chk("err_no_pop", rxq.size(), 2);
        pulse_start();
        step();
        chk("err_sticky", {err, busy}, 2'b10);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("err_reset", {err, busy, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
